// File: rtl/sfu_array.sv
// sfu_array: multi-lane special function unit.
// Accumulates one saturating signed partial sum per output channel over a tile
// of beats delimited by in_last, then applies optional ReLU and holds the tile
// result behind a valid/ready output register. The out_valid flag is the only
// control state; the beat counter is the only tile-position state.
module sfu_array #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [col*psum_bw-1:0]   psum_in,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*psum_bw-1:0]   sfp_out,
    output logic [col-1:0]           out_ovf,
    output logic [cnt_bw-1:0]        out_beats
);

    logic [psum_bw-1:0]       acc [col];
    logic [col-1:0]           ovf;
    logic [cnt_bw-1:0]        cnt;

    logic [psum_bw:0]         sum [col];
    logic [psum_bw-1:0]       sat_val [col];
    logic [col-1:0]           sat_hit;
    logic [col*psum_bw-1:0]   result;
    logic [cnt_bw-1:0]        cnt_inc;
    logic                     in_fire;

    // A held result blocks input unless it is being drained this very cycle,
    // which gives one tile per cycle when tiles are a single beat long.
    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + cnt_bw'(1);

    // Per-lane widened add, clamp on signed overflow, and ReLU on the clamped value.
    always_comb begin
        result  = '0;
        sat_hit = '0;
        for (int c = 0; c < col; c++) begin
            sum[c] = {acc[c][psum_bw-1], acc[c]}
                   + {psum_in[c*psum_bw+psum_bw-1], psum_in[c*psum_bw +: psum_bw]};
            // The two top bits of the widened sum differ only when the true
            // result does not fit in psum_bw bits; the top bit gives the direction.
            sat_hit[c] = sum[c][psum_bw] ^ sum[c][psum_bw-1];
            if (!sat_hit[c]) begin
                sat_val[c] = sum[c][psum_bw-1:0];
            end else if (sum[c][psum_bw]) begin
                sat_val[c] = {1'b1, {(psum_bw-1){1'b0}}};
            end else begin
                sat_val[c] = {1'b0, {(psum_bw-1){1'b1}}};
            end
            result[c*psum_bw +: psum_bw] = (relu_en && sat_val[c][psum_bw-1]) ? '0 : sat_val[c];
        end
    end

    // Tile accumulation state; a last beat hands off to the output and restarts the tile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < col; c++) acc[c] <= '0;
            ovf <= '0;
            cnt <= '0;
        end else if (in_fire) begin
            if (in_last) begin
                for (int c = 0; c < col; c++) acc[c] <= '0;
                ovf <= '0;
                cnt <= '0;
            end else begin
                for (int c = 0; c < col; c++) acc[c] <= sat_val[c];
                ovf <= ovf | sat_hit;
                cnt <= cnt_inc;
            end
        end
    end

    // Output register: loaded by a last beat, released when the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            sfp_out   <= '0;
            out_ovf   <= '0;
            out_beats <= '0;
        end else if (in_fire && in_last) begin
            out_valid <= 1'b1;
            sfp_out   <= result;
            out_ovf   <= ovf | sat_hit;
            out_beats <= cnt_inc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sfu_array.sv
// Testbench for sfu_array: directed scenarios plus randomized tiles, all checked
// against a lane-by-lane integer model of the accumulate/saturate/ReLU rules.
module tb_sfu_array;

    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int CBW = 8;
    localparam int PMAX = 32767;
    localparam int PMIN = -32768;
    localparam int CMAX = 255;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [COL*PBW-1:0]   psum_in;
    logic                 relu_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [COL*PBW-1:0]   sfp_out;
    logic [COL-1:0]       out_ovf;
    logic [CBW-1:0]       out_beats;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int                 m_acc [COL];
    bit                 m_ovf [COL];
    int                 m_cnt;
    logic [COL*PBW-1:0] exp_out;
    logic [COL-1:0]     exp_ovf;
    logic [CBW-1:0]     exp_beats;

    sfu_array #(.col(COL), .psum_bw(PBW), .cnt_bw(CBW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .psum_in(psum_in), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .sfp_out(sfp_out), .out_ovf(out_ovf), .out_beats(out_beats)
    );

    always #5 clk = ~clk;

    function automatic logic [COL*PBW-1:0] mk4(input int a0, input int a1, input int a2, input int a3);
        logic [COL*PBW-1:0] v;
        v = '0;
        v[15:0]  = 16'(a0);
        v[31:16] = 16'(a1);
        v[47:32] = 16'(a2);
        v[63:48] = 16'(a3);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < COL; c++) begin
            m_acc[c] = 0;
            m_ovf[c] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic model_beat(input logic [COL*PBW-1:0] v, input bit last, input bit relu);
        int s;
        for (int c = 0; c < COL; c++) begin
            s = m_acc[c] + int'($signed(v[c*PBW +: PBW]));
            if (s > PMAX) begin
                s = PMAX;
                m_ovf[c] = 1'b1;
            end else if (s < PMIN) begin
                s = PMIN;
                m_ovf[c] = 1'b1;
            end
            m_acc[c] = s;
        end
        m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        if (last) begin
            for (int c = 0; c < COL; c++) begin
                exp_out[c*PBW +: PBW] = (relu && m_acc[c] < 0) ? 16'h0000 : 16'(m_acc[c]);
                exp_ovf[c] = m_ovf[c];
            end
            exp_beats = CBW'(m_cnt);
            model_reset();
        end
    endtask

    // Present one beat; called at the post-edge phase, returns at the next post-edge phase.
    task automatic send(input logic [COL*PBW-1:0] v, input bit last, input bit relu);
        bit accepted;
        in_valid = 1'b1;
        in_last  = last;
        relu_en  = relu;
        psum_in  = v;
        #1;
        accepted = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (accepted) model_beat(v, last, relu);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        // hold a result, then reset asynchronously mid-cycle
        out_ready = 1'b0;
        send(mk4(123, -5, 7, 8), 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_valid out_valid=%b required 1", out_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sfp_out !== '0 || out_ovf !== '0 || out_beats !== '0) begin
            failures++;
            $display("FAIL reset_async out_valid=%b sfp_out=%h out_ovf=%h out_beats=%0d required all zero",
                     out_valid, sfp_out, out_ovf, out_beats);
        end
        #1 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready in_ready=%b required 1", in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_tile3(input bit relu);
        out_ready = 1'b1;
        send(mk4(5, -4, 0, 0), 1'b0, relu);
        send(mk4(-2, -4, 0, 0), 1'b0, relu);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL tile3_early_valid relu=%0d out_valid=%b required 0", relu, out_valid);
        end
        send(mk4(10, 1, 0, 0), 1'b1, relu);
        checks++;
        if (out_valid !== 1'b1 || sfp_out[15:0] !== 16'd13 ||
            sfp_out[31:16] !== (relu ? 16'h0000 : 16'hFFF9) ||
            out_beats !== 8'd3 || out_ovf !== 8'h00) begin
            failures++;
            $display("FAIL tile3 relu=%0d valid=%b l0=%h l1=%h beats=%0d ovf=%h required 1/000d/%h/3/00",
                     relu, out_valid, sfp_out[15:0], sfp_out[31:16], out_beats, out_ovf,
                     relu ? 16'h0000 : 16'hFFF9);
        end
        checks++;
        if (sfp_out !== exp_out) begin
            failures++;
            $display("FAIL tile3_model relu=%0d got=%h required=%h", relu, sfp_out, exp_out);
        end
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL tile3_drain out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        send(mk4(0, 0, 'h7000, -28672), 1'b0, 1'b0);
        send(mk4(0, 0, 'h7000, -28672), 1'b1, 1'b0);
        checks++;
        if (sfp_out[47:32] !== 16'h7FFF || sfp_out[63:48] !== 16'h8000 || out_ovf !== 8'b0000_1100) begin
            failures++;
            $display("FAIL saturation l2=%h l3=%h ovf=%b required 7fff/8000/00001100",
                     sfp_out[47:32], sfp_out[63:48], out_ovf);
        end
        send(mk4(1, 2, 3, 4), 1'b1, 1'b0);
        checks++;
        if (out_ovf !== 8'h00 || sfp_out !== exp_out) begin
            failures++;
            $display("FAIL saturation_next ovf=%b out=%h required 00000000/%h", out_ovf, sfp_out, exp_out);
        end
        idle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(mk4(9, -9, 0, 0), 1'b1, 1'b1);
        in_valid = 1'b1;
        in_last  = 1'b0;
        relu_en  = 1'b1;
        psum_in  = mk4(100, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sfp_out !== exp_out ||
                out_beats !== 8'd1 || sfp_out[15:0] !== 16'd9) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d in_ready=%b valid=%b out=%h beats=%0d required 0/1/%h/1",
                         i, in_ready, out_valid, sfp_out, out_beats, exp_out);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        model_beat(mk4(100, 0, 0, 0), 1'b0, 1'b1);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_drain out_valid=%b required 0", out_valid);
        end
        send(mk4(5, 0, 0, 0), 1'b1, 1'b1);
        checks++;
        if (sfp_out[15:0] !== 16'd105 || out_beats !== 8'd2 || sfp_out !== exp_out) begin
            failures++;
            $display("FAIL backpressure_next l0=%0d beats=%0d required 105/2", sfp_out[15:0], out_beats);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            send(mk4(k, 0, 0, 0), 1'b1, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || sfp_out[15:0] !== 16'(k) || out_beats !== 8'd1) begin
                failures++;
                $display("FAIL back_to_back k=%0d valid=%b l0=%0d beats=%0d required 1/%0d/1",
                         k, out_valid, sfp_out[15:0], out_beats, k);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_tile();
        out_ready = 1'b1;
        send(mk4(7, 0, 0, 0), 1'b0, 1'b0);
        send(mk4(7, 0, 0, 0), 1'b0, 1'b0);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        send(mk4(1, 0, 0, 0), 1'b0, 1'b0);
        send(mk4(1, 0, 0, 0), 1'b1, 1'b0);
        checks++;
        if (sfp_out[15:0] !== 16'd2 || out_beats !== 8'd2 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_tile l0=%0d beats=%0d valid=%b required 2/2/1",
                     sfp_out[15:0], out_beats, out_valid);
        end
        idle();
    endtask

    task automatic test_count_sat();
        out_ready = 1'b1;
        for (int i = 0; i < 299; i++) send(mk4(0, 1, 0, 0), 1'b0, 1'b0);
        send(mk4(0, 1, 0, 0), 1'b1, 1'b0);
        checks++;
        if (out_beats !== 8'd255 || out_beats !== exp_beats || sfp_out[31:16] !== 16'd300) begin
            failures++;
            $display("FAIL count_sat beats=%0d l1=%0d required 255/300", out_beats, sfp_out[31:16]);
        end
        idle();
    endtask

    task automatic test_random();
        int len;
        bit relu;
        logic [COL*PBW-1:0] v;
        out_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            len  = $urandom_range(1, 6);
            relu = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                v = {$urandom, $urandom, $urandom, $urandom};
                if (t % 3 == 0) for (int c = 0; c < COL; c++) v[c*PBW+PBW-1 -: 3] = {3{v[c*PBW+PBW-4]}};
                if ($urandom_range(0, 3) == 0) idle();
                send(v, b == len - 1, relu);
            end
            checks++;
            if (out_valid !== 1'b1 || sfp_out !== exp_out || out_ovf !== exp_ovf || out_beats !== exp_beats) begin
                failures++;
                $display("FAIL random t=%0d valid=%b out=%h ovf=%b beats=%0d required 1/%h/%b/%0d",
                         t, out_valid, sfp_out, out_ovf, out_beats, exp_out, exp_ovf, exp_beats);
            end
        end
        idle();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        relu_en   = 1'b0;
        psum_in   = '0;
        out_ready = 1'b1;
        exp_out   = '0;
        exp_ovf   = '0;
        exp_beats = '0;
        model_reset();
        #22 reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_tile3(1'b1);
        test_tile3(1'b0);
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_tile();
        test_count_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sfu_array.md
Name: sfu_array

Overview:
- Multi-channel special function unit between the psum memory read port and the output/activation memory write path.
- Accumulates one partial sum per output channel (col lanes in parallel) over a variable-length tile of beats.
- Applies optional ReLU with saturating arithmetic, and presents the finished tile result over a valid/ready handshake with backpressure.

Parameters:
- col, 8, number of output channels (lanes) processed in parallel
- psum_bw, 16, signed width of each lane's partial sum, accumulator and output
- cnt_bw, 8, width of the per-tile beat counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  psum_in beat is valid
- in_ready  output  1  block can accept a beat this cycle
- in_last  input  1  qualifies the final beat of a tile
- psum_in  input  col*psum_bw  packed signed psums; lane c at [c*psum_bw +: psum_bw]
- relu_en  input  1  mode select, sampled on the last beat: 1 = ReLU, 0 = signed pass-through
- out_valid  output  1  sfp_out/out_ovf/out_beats hold a completed tile
- out_ready  input  1  consumer accepts the output this cycle
- sfp_out  output  col*psum_bw  packed per-lane tile results, same lane packing as psum_in
- out_ovf  output  col  per-lane flag: saturation occurred at least once in this tile
- out_beats  output  cnt_bw  number of beats accumulated in this tile, saturating at 2^cnt_bw-1

Behaviour:
- Reset (async, any time, including mid-tile or while out_valid=1):
  - all accumulators, sticky ovf flags and the beat counter clear to 0
  - sfp_out=0, out_ovf=0, out_beats=0, out_valid=0
  - in_ready=1 combinationally once reset deasserts
- Handshake:
  - in_ready = !out_valid || out_ready (pure combinational)
  - A beat transfers when in_valid && in_ready; no state changes on non-transfer cycles.
  - Output transfers when out_valid && out_ready.
- Lane arithmetic, on each transfer, per lane c:
  - s = acc[c] + psum_in lane c, computed at psum_bw+1 bits
  - if s > 2^(psum_bw-1)-1, clamp to max; if s < -2^(psum_bw-1), clamp to min; set ovf[c] on either clamp
  - Beat counter increments, saturating at 2^cnt_bw-1.
- Non-last beat: acc[c] <= sat(s).
- Last beat (in_last=1 on a transfer):
  - sfp_out lane c <= relu_en ? (sat(s) negative ? 0 : sat(s)) : sat(s)
  - out_ovf <= ovf | this beat's saturation; out_beats <= counter+1 (saturating)
  - out_valid <= 1
  - acc, ovf and the counter clear to 0 in the same edge
  - Latency: out_valid rises on the edge that accepts the last beat, i.e. data is visible the following cycle.
  - A single-beat tile (in_last on the first beat) yields relu(psum_in).
- Simultaneous last-beat transfer and output transfer in the same cycle: the new result overwrites the register and out_valid stays 1. Result-to-result throughput is one tile per cycle.
- Output accepted with no new last beat: out_valid <= 0. sfp_out, out_ovf and out_beats retain their values, which are don't-care while out_valid=0.
- While out_valid && !out_ready:
  - in_ready=0, so no beats are accepted, including non-last beats
  - output bus stays stable
- The ReLU sign test is on the saturated value; -0 does not exist in two's complement, so there is no special case.
- There is no FSM beyond the out_valid flag. The beat counter is the only tile-position state, and the tile boundary is defined solely by in_last.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> out_valid=0, sfp_out=0, out_ovf=0, out_beats=0 immediately; after release in_ready=1.
- 3-beat tile, relu_en=1, out_ready=1: lane0 5,-2,10; lane1 -4,-4,1 -> lane0=13, lane1=0, out_beats=3, out_ovf=0, out_valid high exactly one cycle after the last-beat edge. Repeat with relu_en=0 -> lane1=0xFFF9 (-7).
- Saturation, relu_en=0: lane2 0x7000,0x7000 -> 0x7FFF, out_ovf[2]=1. Lane3 0x9000,0x9000 -> 0x8000, out_ovf[3]=1. Other ovf bits 0; next tile's ovf starts cleared.
- Backpressure: hold out_ready=0 after a tile completes and drive in_valid=1 -> in_ready=0, output bus stable for 10 cycles, no beats absorbed. Raise out_ready -> in_ready=1 that cycle; the beat presented is accepted into the next tile.
- Back-to-back single-beat tiles, in_valid=in_last=out_ready=1 for 4 cycles with lane0 1,2,3,4 -> outputs 1,2,3,4 on consecutive cycles, each with out_beats=1.
- Reset after 2 of 3 beats (lane0 7,7), then a new 2-beat tile 1,1 -> lane0 result 2, out_beats=2; no residue from the pre-reset beats.
